// File: rtl/debounced_pio.sv
// Avalon-MM input PIO with per-channel synchroniser, debounce filter and
// selectable-edge capture feeding a maskable level interrupt.

module debounced_pio_lane #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit IDLE_HIGH       = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic raw,
  output logic deb,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1, s2, deb_q;
  logic [CW-1:0] cnt;

  // Any cycle where s2 agrees with deb restarts the count, so only a level
  // held for DEBOUNCE_CYCLES consecutive cycles is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1    <= IDLE_HIGH;
      s2    <= IDLE_HIGH;
      deb   <= IDLE_HIGH;
      deb_q <= IDLE_HIGH;
      cnt   <= '0;
    end else begin
      s1    <= pin;
      s2    <= s1;
      deb_q <= deb;
      if (s2 == deb) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        deb <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign raw  = s2;
  assign rise = deb & ~deb_q;
  assign fall = ~deb & deb_q;
endmodule

module debounced_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit IDLE_HIGH       = 1'b1
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [WIDTH-1:0] pins_in,
  input  logic [2:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);
  localparam logic [2:0] A_DATA = 3'd0;
  localparam logic [2:0] A_MASK = 3'd1;
  localparam logic [2:0] A_MODE = 3'd2;
  localparam logic [2:0] A_CAP  = 3'd3;
  localparam logic [2:0] A_RAW  = 3'd4;

  logic [WIDTH-1:0] raw, deb, rise, fall;
  logic [WIDTH-1:0] irq_mask, edge_mode, edge_cap;
  logic [WIDTH-1:0] sel_edge, clr;
  logic [31:0]      rd_mux;
  logic             unused_wd;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    debounced_pio_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .IDLE_HIGH      (IDLE_HIGH)
    ) u_lane (
      .clk  (clk_clk),
      .rst_n(reset_reset_n),
      .pin  (pins_in[i]),
      .raw  (raw[i]),
      .deb  (deb[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

  assign sel_edge  = (rise & ~edge_mode) | (fall & edge_mode);
  assign clr       = (write && address == A_CAP) ? writedata[WIDTH-1:0] : '0;
  assign unused_wd = ^writedata;

  always_comb begin
    rd_mux = '0;
    case (address)
      A_DATA:  rd_mux[WIDTH-1:0] = deb;
      A_MASK:  rd_mux[WIDTH-1:0] = irq_mask;
      A_MODE:  rd_mux[WIDTH-1:0] = edge_mode;
      A_CAP:   rd_mux[WIDTH-1:0] = edge_cap;
      A_RAW:   rd_mux[WIDTH-1:0] = raw;
      default: rd_mux = '0;
    endcase
  end

  // A new edge is OR-ed in after the W1C clear, so it wins a same-cycle race.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      irq_mask  <= '0;
      edge_mode <= '0;
      edge_cap  <= '0;
      readdata  <= '0;
    end else begin
      if (write && address == A_MASK) irq_mask  <= writedata[WIDTH-1:0];
      if (write && address == A_MODE) edge_mode <= writedata[WIDTH-1:0];
      edge_cap <= (edge_cap & ~clr) | sel_edge;
      if (read) readdata <= rd_mux;
    end
  end

  assign irq = |(edge_cap & irq_mask);
endmodule
